// File: rtl/div.sv
// Multi-cycle 32-bit integer divider for the EX stage (DIV / DIVU).
// Restoring radix-2 algorithm: one quotient bit per clock, 32 steps.
// The result is {remainder, quotient}, which EX writes to {HI, LO}.
//
// Handshake: EX raises start_i and holds it high until it sees success_o.
// success_o stays high, with result_o stable, for as long as start_i stays high.
// Dropping start_i before the result is ready abandons the operation.
// cancel_i (pipeline flush) aborts unconditionally and has priority over start_i.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divider_i,
  input  logic        start_i,
  input  logic        cancel_i,
  output logic [63:0] result_o,
  output logic        success_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIVZERO = 2'd1,
    ON      = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [5:0]  cnt;       // completed iteration count
  logic [64:0] work;      // {partial remainder[32:0], dividend bits still to shift in}
  logic [31:0] divisor;   // absolute value of the divisor
  logic        sign_dvd;  // dividend was negative (signed mode only)
  logic        sign_dvr;  // divisor was negative (signed mode only)

  logic        accept;
  logic        step;
  logic [31:0] dvd_abs;
  logic [31:0] dvr_abs;
  logic [33:0] trial;
  logic [64:0] work_step;
  logic [31:0] q_raw;
  logic [31:0] r_raw;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic [31:0] dvd_orig;

  // Next-state logic; a flush wins over everything else.
  always_comb begin
    state_next = state;
    if (cancel_i) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_i) state_next = (divider_i == 32'd0) ? DIVZERO : ON;
        DIVZERO: state_next = start_i ? DONE : IDLE;
        ON: begin
          if (!start_i)          state_next = IDLE;
          else if (cnt == 6'd31) state_next = DONE;
        end
        DONE:    if (!start_i) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Operand conditioning, one restoring step, and the sign fix-up of the result.
  always_comb begin
    accept   = (state == IDLE) && start_i && !cancel_i;
    step     = (state == ON) && start_i && !cancel_i;
    dvd_abs  = (signed_i && dividend_i[31]) ? -dividend_i : dividend_i;
    dvr_abs  = (signed_i && divider_i[31])  ? -divider_i  : divider_i;
    // Trial subtraction: {remainder, next dividend bit} minus the divisor.
    // Bit 33 is the borrow; when it is set the remainder is restored.
    trial    = {work[64:32], work[31]} - {2'b00, divisor};
    if (!trial[33]) work_step = {trial[32:0], work[30:0], 1'b1};
    else            work_step = {work[63:0], 1'b0};
    q_raw    = work_step[31:0];
    r_raw    = work_step[63:32];
    // Modulo-2^32 negation also yields 0x80000000 / -1 = 0x80000000, remainder 0.
    q_fix    = (sign_dvd ^ sign_dvr) ? -q_raw : q_raw;
    r_fix    = sign_dvd ? -r_raw : r_raw;
    // The dividend is held as an absolute value; rebuild the original for divide-by-zero.
    dvd_orig = sign_dvd ? -work[31:0] : work[31:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= 6'd0;
      work      <= 65'd0;
      divisor   <= 32'd0;
      sign_dvd  <= 1'b0;
      sign_dvr  <= 1'b0;
      result_o  <= 64'h0;
      success_o <= 1'b0;
    end else begin
      if (accept) begin
        sign_dvd <= signed_i && dividend_i[31];
        sign_dvr <= signed_i && divider_i[31];
        divisor  <= dvr_abs;
        work     <= {33'd0, dvd_abs};
        cnt      <= 6'd0;
      end else if (step) begin
        work <= work_step;
        cnt  <= cnt + 6'd1;
      end
      if ((state == ON) && (state_next == DONE)) begin
        result_o <= {r_fix, q_fix};
      end else if ((state == DIVZERO) && (state_next == DONE)) begin
        result_o <= {dvd_orig, 32'hFFFF_FFFF};
      end
      success_o <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed corner cases plus random operands,
// compared against a plain-arithmetic reference model.
module tb_div;

  logic        clk;
  logic        rst;
  logic        signed_i;
  logic [31:0] dividend_i;
  logic [31:0] divider_i;
  logic        start_i;
  logic        cancel_i;
  logic [63:0] result_o;
  logic        success_o;

  int          n_cmp;
  int          n_err;
  logic [63:0] exp_q[$];

  div dut (
    .clk        (clk),
    .rst        (rst),
    .signed_i   (signed_i),
    .dividend_i (dividend_i),
    .divider_i  (divider_i),
    .start_i    (start_i),
    .cancel_i   (cancel_i),
    .result_o   (result_o),
    .success_o  (success_o)
  );

  // Clock and reset defaults.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: {remainder, quotient} from ordinary integer division.
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, lq, lr;
    logic [63:0] uq, ur;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!sgn) begin
      uq = {32'd0, a} / {32'd0, b};
      ur = {32'd0, a} % {32'd0, b};
      return {ur[31:0], uq[31:0]};
    end
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lq = sa / sb;
    lr = sa % sb;
    return {lr[31:0], lq[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one divide from a negedge; hold start until success, optionally keep it
  // high for hold_cyc more cycles, then drop it and confirm the block went idle.
  // Returns at a negedge so the next request can follow with no gap.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input int hold_cyc, input string tag);
    int edges;
    int lat;
    logic seen;
    logic [63:0] exp;
    signed_i   = sgn;
    dividend_i = a;
    divider_i  = b;
    start_i    = 1'b1;
    exp_q.push_back(model(sgn, a, b));
    lat   = (b == 32'd0) ? 2 : 33;
    edges = 0;
    seen  = 1'b0;
    while (edges < 60 && !seen) begin
      @(negedge clk);
      edges++;
      // Operands are latched at the accepting edge; later changes must not matter.
      signed_i   = 1'($urandom);
      dividend_i = $urandom;
      divider_i  = $urandom;
      if (success_o) seen = 1'b1;
    end
    exp = exp_q.pop_front();
    chk({tag, "_latency"}, 64'(edges), 64'(lat));
    chk({tag, "_result"}, result_o, exp);
    for (int i = 0; i < hold_cyc; i++) begin
      @(negedge clk);
      chk({tag, "_hold_success"}, 64'(success_o), 64'd1);
      chk({tag, "_hold_result"}, result_o, exp);
    end
    start_i = 1'b0;
    @(negedge clk);
    chk({tag, "_drop_success"}, 64'(success_o), 64'd0);
    chk({tag, "_idle_result"}, result_o, exp);
  endtask

  // Directed and random stimulus.
  initial begin
    logic [63:0] prev;
    logic        seen;
    logic [31:0] ra, rb;
    logic        rs;
    n_cmp      = 0;
    n_err      = 0;
    rst        = 1'b0;
    signed_i   = 1'b0;
    dividend_i = 32'd0;
    divider_i  = 32'd0;
    start_i    = 1'b0;
    cancel_i   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_result", result_o, 64'h0);
    chk("reset_success", 64'(success_o), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_success", 64'(success_o), 64'd0);

    run_div(1'b0, 32'd100, 32'd7, 3, "u100_7");
    chk("u100_7_const", result_o, 64'h0000_0002_0000_000E);
    run_div(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 0, "s_m7_2");
    chk("s_m7_2_const", result_o, 64'hFFFF_FFFF_FFFF_FFFD);
    run_div(1'b0, 32'h1234_5678, 32'd0, 1, "divzero");
    chk("divzero_const", result_o, 64'h1234_5678_FFFF_FFFF);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "s_min_m1");
    chk("s_min_m1_const", result_o, 64'h0000_0000_8000_0000);
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 0, "u_max_1");
    chk("u_max_1_const", result_o, 64'h0000_0000_FFFF_FFFF);
    run_div(1'b1, 32'hFFFF_FFF0, 32'd0, 0, "s_divzero_neg");

    // Flush in the middle of an operation.
    prev       = result_o;
    signed_i   = 1'b0;
    dividend_i = 32'd1000;
    divider_i  = 32'd3;
    start_i    = 1'b1;
    repeat (10) @(negedge clk);
    cancel_i = 1'b1;
    @(negedge clk);
    cancel_i = 1'b0;
    start_i  = 1'b0;
    seen     = success_o;
    repeat (40) begin
      @(negedge clk);
      if (success_o) seen = 1'b1;
    end
    chk("cancel_no_success", 64'(seen), 64'd0);
    chk("cancel_result_kept", result_o, prev);
    run_div(1'b0, 32'd9, 32'd3, 0, "u9_3");
    chk("u9_3_const", result_o, 64'h0000_0000_0000_0003);

    // Asynchronous reset in the middle of an operation.
    signed_i   = 1'b0;
    dividend_i = 32'd12345;
    divider_i  = 32'd7;
    start_i    = 1'b1;
    repeat (21) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midreset_result", result_o, 64'h0);
    chk("midreset_success", 64'(success_o), 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst  = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (success_o) seen = 1'b1;
    end
    chk("postreset_idle", 64'(seen), 64'd0);
    run_div(1'b0, 32'd10, 32'd4, 0, "u10_4");
    chk("u10_4_const", result_o, 64'h0000_0002_0000_0002);

    // Random operands, back to back.
    for (int i = 0; i < 24; i++) begin
      rs = 1'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = -32'($urandom_range(1, 15));
        3:       rb = ra;
        default: rb = $urandom;
      endcase
      run_div(rs, ra, rb, 0, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
